// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared FSM state type and requester identifiers for the memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} t_arb_state;
    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant; i_last names the requester served last.
import mem_arb_pkg::*;
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);
    assign o_gnt[0] = i_req[0] & (~i_req[1] | (i_last == REQ_DCACHE));
    assign o_gnt[1] = i_req[1] & (~i_req[0] | (i_last == REQ_ICACHE));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI master between the I-cache and D-cache, one transaction at a time,
// with round-robin grant, a completion watchdog and per-requester response routing.
import mem_arb_pkg::*;
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_req0_valid,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    output logic                  o_req0_ready,
    output logic [DATA_WIDTH-1:0] o_rsp0_data,
    output logic                  o_rsp0_valid,
    output logic                  o_rsp0_err,
    input  logic                  i_req1_valid,
    input  logic                  i_req1_write,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    output logic                  o_req1_ready,
    output logic [DATA_WIDTH-1:0] o_rsp1_data,
    output logic                  o_rsp1_valid,
    output logic                  o_rsp1_err,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_start_read,
    output logic                  o_start_write,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    t_arb_state            r_state, w_next;
    logic                  r_owner, r_write, r_last;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data, r_rsp0_data, r_rsp1_data;
    logic                  r_rsp0_err, r_rsp1_err;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            w_gnt;
    logic                  w_accept, w_expire, w_done;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    rr_arb2 u_rr (
        .i_req  ({i_req1_valid, i_req0_valid}),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    assign w_accept   = (r_state == IDLE) && (|w_gnt);
    // A completion arriving in the final watchdog cycle wins over the timeout.
    assign w_expire   = (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !i_valid;
    assign w_done     = (r_state == WAIT) && (i_valid || w_expire);
    assign w_rsp_data = (i_valid && !r_write) ? i_data : '0;

    always_ff @(posedge clk) begin
        if (!arstn) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        o_req0_ready  = 1'b0;
        o_req1_ready  = 1'b0;
        o_start_read  = 1'b0;
        o_start_write = 1'b0;
        o_rsp0_valid  = 1'b0;
        o_rsp1_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                o_req0_ready = w_gnt[0];
                o_req1_ready = w_gnt[1];
                w_next       = w_accept ? ISSUE : IDLE;
            end
            ISSUE: begin
                o_start_read  = !r_write;
                o_start_write = r_write;
                w_next        = WAIT;
            end
            WAIT: w_next = w_done ? RESP : WAIT;
            RESP: begin
                o_rsp0_valid = (r_owner == REQ_ICACHE);
                o_rsp1_valid = (r_owner == REQ_DCACHE);
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_owner     <= REQ_ICACHE;
            r_write     <= 1'b0;
            r_last      <= REQ_DCACHE;
            r_addr      <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_rsp0_data <= '0;
            r_rsp0_err  <= 1'b0;
            r_rsp1_data <= '0;
            r_rsp1_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= w_gnt[1];
                r_last  <= w_gnt[1];
                r_write <= w_gnt[1] & i_req1_write;
                r_addr  <= w_gnt[1] ? i_req1_addr : i_req0_addr;
                r_data  <= w_gnt[1] ? i_req1_data : '0;
            end
            r_cnt <= (r_state == ISSUE) ? '0 : (r_state == WAIT) ? r_cnt + CW'(1) : r_cnt;
            if (w_done && r_owner == REQ_ICACHE) begin
                r_rsp0_data <= w_rsp_data;
                r_rsp0_err  <= !i_valid;
            end
            if (w_done && r_owner == REQ_DCACHE) begin
                r_rsp1_data <= w_rsp_data;
                r_rsp1_err  <= !i_valid;
            end
        end
    end

    assign o_addr      = r_addr;
    assign o_data      = r_data;
    assign o_rsp0_data = r_rsp0_data;
    assign o_rsp0_err  = r_rsp0_err;
    assign o_rsp1_data = r_rsp1_data;
    assign o_rsp1_err  = r_rsp1_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; a transaction-level model predicts grants, issue pulses and responses.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          i_req0_valid = 1'b0, i_req1_valid = 1'b0, i_req1_write = 1'b0;
    logic [AW-1:0] i_req0_addr = '0, i_req1_addr = '0;
    logic [DW-1:0] i_req1_data = '0;
    logic          o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp0_err, o_rsp1_err;
    logic [DW-1:0] o_rsp0_data, o_rsp1_data, o_data;
    logic [AW-1:0] o_addr;
    logic          o_start_read, o_start_write;
    logic [DW-1:0] i_data = '0;
    logic          i_valid = 1'b0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .arstn(arstn),
        .i_req0_valid(i_req0_valid), .i_req0_addr(i_req0_addr), .o_req0_ready(o_req0_ready),
        .o_rsp0_data(o_rsp0_data), .o_rsp0_valid(o_rsp0_valid), .o_rsp0_err(o_rsp0_err),
        .i_req1_valid(i_req1_valid), .i_req1_write(i_req1_write), .i_req1_addr(i_req1_addr),
        .i_req1_data(i_req1_data), .o_req1_ready(o_req1_ready),
        .o_rsp1_data(o_rsp1_data), .o_rsp1_valid(o_rsp1_valid), .o_rsp1_err(o_rsp1_err),
        .o_addr(o_addr), .o_data(o_data), .o_start_read(o_start_read), .o_start_write(o_start_write),
        .i_data(i_data), .i_valid(i_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; bit port; logic [DW-1:0] data; bit err;} rsp_t;
    typedef struct {int cyc; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data;} iss_t;
    typedef struct {int k; bit resp; bit spur; logic [DW-1:0] data;} plan_t;
    rsp_t rq[$];
    iss_t iq[$];
    plan_t pq[$];
    bit grants[$];

    int checks = 0, errors = 0;
    bit last = 1'b1;
    int busy_until = -1;
    bit p0v = 0, p1v = 0, p1w = 0;
    logic [AW-1:0] p0a = '0, p1a = '0;
    logic [DW-1:0] p1d = '0;
    bit use_forced = 0, no_rsp = 0, rand_on = 0;
    plan_t forced;
    int accepted = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_rsp0_valid || o_rsp1_valid) begin
            rsp_t e;
            chk("rsp_onehot", 64'(o_rsp0_valid & o_rsp1_valid), 64'd0);
            chk("rsp_expected", 64'(rq.size() != 0), 64'd1);
            if (rq.size() != 0) begin
                e = rq.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("rsp_port", 64'(o_rsp1_valid), 64'(e.port));
                chk("rsp_data", 64'(e.port ? o_rsp1_data : o_rsp0_data), 64'(e.data));
                chk("rsp_err", 64'(e.port ? o_rsp1_err : o_rsp0_err), 64'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (o_start_read || o_start_write) begin
            iss_t s;
            chk("start_onehot", 64'(o_start_read & o_start_write), 64'd0);
            chk("start_expected", 64'(iq.size() != 0), 64'd1);
            if (iq.size() != 0) begin
                s = iq.pop_front();
                chk("start_cycle", 64'(cyc), 64'(s.cyc));
                chk("start_write", 64'(o_start_write), 64'(s.wr));
                chk("start_addr", o_addr, s.addr);
                if (s.wr) chk("start_wdata", 64'(o_data), 64'(s.data));
            end
        end
    end

    // AXI master stand-in: follows the plan chosen when the request was accepted.
    initial begin
        plan_t p;
        @(posedge arstn);
        @(posedge clk); #1 i_valid = 1'b1; i_data = '1;
        repeat (3) @(posedge clk);
        #1 i_valid = 1'b0;
        forever begin
            @(negedge clk);
            if ((o_start_read || o_start_write) && pq.size() != 0) begin
                p = pq.pop_front();
                if (p.spur) begin i_valid = 1'b1; i_data = $urandom; end
                @(posedge clk); #1 i_valid = 1'b0;
                if (p.resp) begin
                    repeat (p.k) @(posedge clk);
                    #1 i_valid = 1'b1; i_data = p.data;
                    @(posedge clk); #1 i_valid = p.spur; i_data = $urandom;
                    @(posedge clk);
                    @(posedge clk); #1 i_valid = 1'b0;
                end
            end
        end
    end

    task automatic accept(input bit port);
        plan_t p;
        rsp_t r;
        iss_t s;
        if (use_forced) begin
            p = forced;
            use_forced = 0;
        end else begin
            p.resp = ($urandom_range(7, 0) != 0);
            p.k    = $urandom_range(TO - 1, 0);
            p.spur = $urandom_range(1, 0) == 1;
            p.data = $urandom;
        end
        s.cyc  = cyc + 1;
        s.wr   = port & p1w;
        s.addr = port ? p1a : p0a;
        s.data = p1d;
        r.cyc  = p.resp ? cyc + 3 + p.k : cyc + 2 + TO;
        r.port = port;
        r.data = (p.resp && !s.wr) ? p.data : '0;
        r.err  = !p.resp;
        busy_until = r.cyc;
        last = port;
        iq.push_back(s);
        pq.push_back(p);
        if (!no_rsp) rq.push_back(r);
        grants.push_back(port);
        accepted++;
        if (port) p1v = 0; else p0v = 0;
    endtask

    task automatic drive();
        if (rand_on && !p0v && $urandom_range(3, 0) == 0) begin
            p0v = 1; p0a = {$urandom, $urandom};
        end
        if (rand_on && !p1v && $urandom_range(3, 0) == 0) begin
            p1v = 1; p1w = $urandom_range(1, 0) == 1; p1a = {$urandom, $urandom}; p1d = $urandom;
        end
        i_req0_valid = p0v; i_req0_addr = p0a;
        i_req1_valid = p1v; i_req1_write = p1w; i_req1_addr = p1a; i_req1_data = p1d;
    endtask

    task automatic step();
        bit idle, g0, g1;
        @(negedge clk);
        idle = cyc > busy_until;
        g0 = idle && p0v && (!p1v || last);
        g1 = idle && p1v && (!p0v || !last);
        chk("ready", 64'({o_req1_ready, o_req0_ready}), 64'({g1, g0}));
        if (g0 || g1) accept(g1);
        @(posedge clk); #1 drive();
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while ((p0v || p1v || cyc <= busy_until + 1) && n < limit) begin
            step();
            n++;
        end
        chk("idle_bound", 64'(n < limit), 64'd1);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'({o_req1_ready, o_req0_ready}), 64'd0);
        chk({tag, "_start"}, 64'({o_start_write, o_start_read}), 64'd0);
        chk({tag, "_rspv"}, 64'({o_rsp1_valid, o_rsp0_valid}), 64'd0);
        chk({tag, "_err"}, 64'({o_rsp1_err, o_rsp0_err}), 64'd0);
        chk({tag, "_rspd"}, {o_rsp1_data, o_rsp0_data}, 64'd0);
        chk({tag, "_addr"}, o_addr, 64'd0);
        chk({tag, "_data"}, 64'(o_data), 64'd0);
    endtask

    task automatic set_forced(input bit resp, input int k, input logic [DW-1:0] d, input bit spur);
        forced.resp = resp; forced.k = k; forced.data = d; forced.spur = spur; use_forced = 1;
    endtask

    initial begin
        int n, acc_cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_outputs("reset");
        @(posedge clk); #1 arstn = 1'b1;
        repeat (8) step();

        p0v = 1; p0a = 64'h1000;
        set_forced(1, 2, 32'hDEADBEEF, 1);
        drive();
        run_until_idle(100);

        p1v = 1; p1w = 1; p1a = 64'h2000; p1d = 32'h12345678;
        set_forced(1, 3, 32'hFFFF0000, 0);
        drive();
        run_until_idle(100);

        n = grants.size();
        for (int r = 0; r < 2; r++) begin
            p0v = 1; p0a = 64'h3000 + 64'(r); p1v = 1; p1w = 0; p1a = 64'h4000 + 64'(r); p1d = 32'h0;
            drive();
            run_until_idle(200);
        end
        chk("tie_order", 64'({grants[n], grants[n+1], grants[n+2], grants[n+3]}), 64'b0101);

        p1v = 1; p1w = 0; p1a = 64'h5000;
        set_forced(0, 0, 32'h0, 1);
        drive();
        run_until_idle(100);

        p0v = 1; p0a = 64'h6000;
        set_forced(1, TO - 1, 32'hA5A5C3C3, 1);
        drive();
        run_until_idle(100);

        rand_on = 1;
        n = 0;
        while (accepted < 50 && n < 3000) begin
            step();
            n++;
        end
        chk("random_bound", 64'(n < 3000), 64'd1);
        rand_on = 0;
        run_until_idle(200);

        p0v = 1; p0a = 64'h7000;
        set_forced(1, 5, 32'h0BADF00D, 0);
        no_rsp = 1;
        drive();
        n = accepted;
        while (accepted == n && cyc < 90000) step();
        acc_cyc = cyc - 1;
        no_rsp = 0;
        @(posedge clk); #1 arstn = 1'b0;
        @(posedge clk); #1 arstn = 1'b1;
        busy_until = cyc - 1;
        last = 1'b1;
        @(negedge clk);
        reset_outputs("midwait");
        while (cyc < acc_cyc + 12) step();
        n = grants.size();
        p0v = 1; p0a = 64'h8000; p1v = 1; p1w = 1; p1a = 64'h9000; p1d = 32'hCAFE0001;
        drive();
        run_until_idle(200);
        chk("post_reset_order", 64'({grants[n], grants[n+1]}), 64'b01);
        repeat (5) step();
        chk("rsp_drained", 64'(rq.size()), 64'd0);
        chk("issue_drained", 64'(iq.size()), 64'd0);
        chk("plan_drained", 64'(pq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end
endmodule
